// File: rtl/seg_frame_feeder.sv
// seg_frame_feeder: double-buffered 8-slot source for the multiplexed display link.
module seg_frame_feeder #(
    parameter int PRESCALE = 1000,
    parameter int CW       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] enc_data,
    input  logic [15:0] plain_data,
    output logic [3:0]  enword,
    output logic [3:0]  word,
    output logic [1:0]  enrw,
    output logic [1:0]  worw,
    output logic        pending,
    output logic        frame_done
);
    logic [CW-1:0] count;
    logic [2:0]    slot;
    logic [2:0]    slot_n;
    logic [1:0]    code;
    logic [3:0]    base;
    logic [15:0]   act_enc;
    logic [15:0]   act_plain;
    logic [15:0]   sh_enc;
    logic [15:0]   sh_plain;
    logic          tick;
    logic          boundary;
    logic          bnd_d;

    assign tick     = count == CW'(PRESCALE - 1);
    assign boundary = tick && slot == 3'd7;
    assign slot_n   = slot + 3'd1;
    // slot codes count 01,10,11,00 within each half; the idle half holds 01
    assign code     = slot_n[1:0] == 2'd0 ? 2'b01 : slot_n[1:0] + 2'd1;
    assign base     = {~slot[1:0], 2'b11};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            slot       <= '0;
            enrw       <= 2'b01;
            worw       <= 2'b01;
            enword     <= '0;
            word       <= '0;
            act_enc    <= '0;
            act_plain  <= '0;
            sh_enc     <= '0;
            sh_plain   <= '0;
            pending    <= 1'b0;
            bnd_d      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            count <= tick ? '0 : count + CW'(1);
            if (tick) begin
                slot <= slot_n;
                enrw <= slot_n[2] ? 2'b01 : code;
                worw <= slot_n[2] ? code : 2'b01;
            end
            // nibbles follow the already-updated slot, trailing the codes by one clock
            enword <= act_enc[base -: 4];
            word   <= act_plain[base -: 4];
            if (boundary && pending) begin
                act_enc   <= sh_enc;
                act_plain <= sh_plain;
            end
            if (load) begin
                sh_enc   <= enc_data;
                sh_plain <= plain_data;
            end
            pending    <= load | (pending & ~boundary);
            bnd_d      <= boundary;
            frame_done <= bnd_d;
        end
    end
endmodule

// File: doc/seg_frame_feeder.md
Name: seg_frame_feeder

Overview:
- Source side of the 8-digit multiplexed display link.
- Holds a 16-bit encrypted value and a 16-bit plaintext value and steps through 8 digit slots on a prescaled tick.
- Drives the nibble buses enword/word and the 2-bit slot codes enrw/worw that the display scanner follows.
- Double-buffered: new data loaded mid-frame takes effect only at the frame boundary.

Parameters:
- PRESCALE, 1000, clock cycles per digit slot; legal range 2..65535.
- CW, 16, width of the prescale counter; must satisfy 2^CW >= PRESCALE.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe; captures enc_data/plain_data into the shadow registers
- enc_data  in  16  encrypted value; [15:12] = digit 1 (leftmost)
- plain_data  in  16  plaintext value; [15:12] = digit 5
- enword  out  4  encrypted nibble for the current slot
- word  out  4  plaintext nibble for the current slot
- enrw  out  2  encrypted-half slot code
- worw  out  2  plaintext-half slot code
- pending  out  1  shadow holds data not yet applied
- frame_done  out  1  one-cycle pulse when a frame boundary occurs

Behaviour:
- Reset (reset=0, async): prescale count=0, slot=0, enrw=2'b01, worw=2'b01, enword=0, word=0, active and shadow registers=0, pending=0, frame_done=0.
- Prescaler:
  - count runs 0..PRESCALE-1.
  - tick=1 in the cycle where count==PRESCALE-1; count then wraps to 0.
- Slot counter: 3-bit slot, 0..7, advances on tick, wraps 7->0.
- Slot codes are registered and update on the tick edge together with slot:
  - slot 0: enrw=01, worw=01
  - slots 1,2,3: enrw=10,11,00; worw=01
  - slot 4: enrw=01, worw=01
  - slots 5,6,7: worw=10,11,00; enrw=01
  - Per transition, exactly one of enrw/worw changes, except 3->4 and 7->0, where only enrw (3->4) or only worw (7->0) returns to 01.
- Nibble outputs:
  - enword = active_enc nibble [15-4k -: 4], word = active_plain nibble [15-4k -: 4], with k=slot[1:0].
  - Registered one clock after the slot-code change, so they align with the scanner's registered state change.
  - Latency: tick edge -> enrw/worw new value; +1 clock -> enword/word new value.
- Double buffering:
  - load=1 writes shadow_enc/shadow_plain from the inputs and sets pending=1.
  - Load while pending=1 overwrites the shadow (last load wins).
- Frame boundary = the tick on which slot goes 7->0.
  - If pending=1: active<=shadow, pending<=0.
  - If pending=0: active unchanged.
- frame_done: registered, high for exactly one clock, in the cycle after the boundary tick (same cycle enword shows the new slot-0 nibble).
- Simultaneous load and boundary tick:
  - The boundary transfers the shadow contents from before this cycle.
  - The new data lands in the shadow; pending=1 afterwards.
  - If pending was 0, active is unchanged and the new data waits one full frame.
- No load ever: active stays 0 and frames repeat indefinitely with identical output.
- Reset mid-frame: all state returns to reset values immediately. Codes 01/01 match the scanner's reset state, so no resync is required.
- Data inputs are sampled only when load=1; they are don't-care otherwise.

Test Plan:
- Reset then run, PRESCALE=4, no load -> ticks every 4 clocks. enrw sequence 01,10,11,00,01 then worw 10,11,00,01, repeating every 32 clocks. enword=word=0; frame_done pulses every 32 clocks.
- PRESCALE=4, load enc=16'h1234, plain=16'hABCD at clock 5 -> pending=1 until the first 7->0 tick (clock 31), then pending=0. One clock later frame_done=1 and enword=1. Following frame: enword 1,2,3,4 for slots 0-3, word A,B,C,D for slots 0-3 (and 4-7), each one clock after the matching code change.
- Two loads mid-frame (16'h1111/16'h2222, then 16'h5A5A/16'h0F0F) -> after the boundary, active=5A5A/0F0F; 1111/2222 never appears on enword/word.
- load asserted exactly on the boundary tick with pending=0 -> active unchanged for that frame and pending=1. Transfer happens at the next boundary, 32 clocks later.
- Reset pulsed low during slot 5 with active=16'h1234 -> enrw=worw=01, enword=word=0, slot=0, pending=0 asynchronously. Sequence restarts from slot 0 with counter at 0.
- PRESCALE=2 (minimum) -> slot advances every 2 clocks. enword trails enrw by exactly 1 clock on every transition; frame length is 16 clocks.
